// File: rtl/mac_deskew_collector.sv
// rtl/mac_deskew_collector.sv - per-column FIFOs that re-align the skewed systolic output into full result vectors
module mac_deskew_collector #(
  parameter int COLS  = 8,
  parameter int MAC_W = 32,
  parameter int DEPTH = 16,
  parameter int ROWS  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic [COLS*MAC_W-1:0]  col_mac_i,
  input  logic [COLS-1:0]        col_v_i,
  output logic [COLS*MAC_W-1:0]  out_data_o,
  output logic                   out_v_o,
  input  logic                   out_rdy_i,
  output logic                   out_last_o,
  output logic                   afull_o,
  output logic [COLS-1:0]        ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - COLS);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  logic [MAC_W-1:0] mem_q    [COLS][DEPTH];
  logic [MAC_W-1:0] mem_d    [COLS][DEPTH];
  logic [AW-1:0]    wr_ptr_q [COLS];
  logic [AW-1:0]    wr_ptr_d [COLS];
  logic [AW-1:0]    rd_ptr_q [COLS];
  logic [AW-1:0]    rd_ptr_d [COLS];
  logic [CW-1:0]    cnt_q    [COLS];
  logic [CW-1:0]    cnt_d    [COLS];
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic [COLS-1:0]  ovf_q, ovf_d;
  logic             afull_q, afull_d;
  logic [COLS-1:0]  push;
  logic             pop;

  // A vector exists only once every column holds at least one entry.
  always_comb begin
    out_v_o = 1'b1;
    for (int j = 0; j < COLS; j++) begin
      if (cnt_q[j] == '0) out_v_o = 1'b0;
    end
  end

  assign pop        = out_v_o && out_rdy_i;
  assign out_last_o = out_v_o && (row_cnt_q == LAST_ROW);
  assign afull_o    = afull_q;
  assign ovf_o      = ovf_q;

  always_comb begin
    out_data_o = '0;
    for (int j = 0; j < COLS; j++) begin
      out_data_o[j*MAC_W +: MAC_W] = mem_q[j][rd_ptr_q[j]];
    end
  end

  // A full column still accepts a push when the same cycle pops it.
  always_comb begin
    push = '0;
    for (int j = 0; j < COLS; j++) begin
      push[j] = col_v_i[j] && ((cnt_q[j] != FULL_CNT) || pop);
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    row_cnt_d = row_cnt_q;
    ovf_d     = ovf_q;
    afull_d   = 1'b0;
    if (clr_i) begin
      for (int j = 0; j < COLS; j++) begin
        wr_ptr_d[j] = '0;
        rd_ptr_d[j] = '0;
        cnt_d[j]    = '0;
      end
      row_cnt_d = '0;
      ovf_d     = '0;
    end else begin
      for (int j = 0; j < COLS; j++) begin
        if (cnt_q[j] >= AFULL_CNT) afull_d = 1'b1;
        if (push[j]) begin
          mem_d[j][wr_ptr_q[j]] = col_mac_i[j*MAC_W +: MAC_W];
          wr_ptr_d[j]           = wr_ptr_q[j] + AW'(1);
        end else if (col_v_i[j]) begin
          ovf_d[j] = 1'b1;
        end
        if (pop) rd_ptr_d[j] = rd_ptr_q[j] + AW'(1);
        if (push[j] && !pop)      cnt_d[j] = cnt_q[j] + CW'(1);
        else if (!push[j] && pop) cnt_d[j] = cnt_q[j] - CW'(1);
      end
      if (pop) row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int j = 0; j < COLS; j++) begin
        for (int k = 0; k < DEPTH; k++) mem_q[j][k] <= '0;
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        cnt_q[j]    <= '0;
      end
      row_cnt_q <= '0;
      ovf_q     <= '0;
      afull_q   <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      row_cnt_q <= row_cnt_d;
      ovf_q     <= ovf_d;
      afull_q   <= afull_d;
    end
  end

endmodule
